// File: rtl/parking_pkg.sv
// Shared constants for the parking occupancy tracker: default sizing, counter
// width and the per-slot debounce state encoding (state bit 1 is the parked bit).
package parking_pkg;

    localparam int NUM_SLOTS_DEF       = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    // Wide enough for the full legal debounce range 1..15.
    localparam int CNT_W               = 4;

    localparam logic [1:0] ST_FREE     = 2'b00;
    localparam logic [1:0] ST_ARRIVING = 2'b01;
    localparam logic [1:0] ST_OCCUPIED = 2'b11;
    localparam logic [1:0] ST_LEAVING  = 2'b10;

    function automatic logic state_parked(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/parking_occupancy_tracker_if.sv
// Sensor/occupancy bundle between the raw sensor front end and the lot logic.
interface parking_occupancy_tracker_if #(
    parameter int NUM_SLOTS = parking_pkg::NUM_SLOTS_DEF
);

    logic [NUM_SLOTS-1:0] sensor;
    logic [NUM_SLOTS-1:0] parked;
    logic [NUM_SLOTS-1:0] arrive_pulse;
    logic [NUM_SLOTS-1:0] leave_pulse;
    logic                 changed;
    logic                 full;

    modport master (
        output sensor,
        input  parked, arrive_pulse, leave_pulse, changed, full
    );

    modport slave (
        input  sensor,
        output parked, arrive_pulse, leave_pulse, changed, full
    );

endinterface

// File: rtl/slot_debouncer.sv
// One parking slot: two-flop synchronizer followed by a debounce FSM that only
// changes the occupancy after DEBOUNCE_CYCLES+1 consecutive opposite samples.
module slot_debouncer
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_in,
    output logic parked_out,
    output logic arrive_out,
    output logic leave_out
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic             s1_q, s1_d, s2_q, s2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arrive_q, arrive_d, leave_q, leave_d;

    // Next-state logic for the synchronizer and debounce FSM.
    always_comb begin
        s1_d     = sensor_in;
        s2_d     = s1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        arrive_d = 1'b0;
        leave_d  = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (s2_q) begin
                    state_d = ST_ARRIVING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_ARRIVING: begin
                if (!s2_q) begin
                    state_d = ST_FREE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d  = ST_OCCUPIED;
                    cnt_d    = CNT_ZERO;
                    arrive_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_OCCUPIED: begin
                if (!s2_q) begin
                    state_d = ST_LEAVING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_LEAVING: begin
                if (s2_q) begin
                    state_d = ST_OCCUPIED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_FREE;
                    cnt_d   = CNT_ZERO;
                    leave_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_FREE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, synchronizer and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_FREE;
            cnt_q    <= CNT_ZERO;
            arrive_q <= 1'b0;
            leave_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            arrive_q <= arrive_d;
            leave_q  <= leave_d;
        end
    end

    assign parked_out = state_parked(state_q);
    assign arrive_out = arrive_q;
    assign leave_out  = leave_q;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Per-slot debounced occupancy with arrival/departure pulses and a lot-full flag.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    parking_occupancy_tracker_if.slave    bus
);

    logic [NUM_SLOTS-1:0] parked_s;
    logic [NUM_SLOTS-1:0] arrive_s;
    logic [NUM_SLOTS-1:0] leave_s;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .sensor_in  (bus.sensor[i]),
            .parked_out (parked_s[i]),
            .arrive_out (arrive_s[i]),
            .leave_out  (leave_s[i])
        );
    end

    // changed and full are pure reductions of flop outputs, so they move on
    // exactly the same edge as parked and the pulses with no extra latency.
    assign bus.parked       = parked_s;
    assign bus.arrive_pulse = arrive_s;
    assign bus.leave_pulse  = leave_s;
    assign bus.changed      = |(arrive_s | leave_s);
    assign bus.full         = &parked_s;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed plan steps plus randomized sensor traffic, checked against a
// run-length occupancy model of the debounce rules.
module tb_parking_occupancy_tracker;

    localparam int NS  = 3;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    parking_occupancy_tracker_if #(.NUM_SLOTS(NS)) bus ();

    parking_occupancy_tracker #(
        .NUM_SLOTS       (NS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: sensor delayed two samples; a slot flips after DEB+1
    // consecutive delayed samples that disagree with its occupancy.
    logic [NS-1:0] m_d1, m_d2, m_parked, m_arr, m_lea;
    int            run_len [NS];

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_parked = '0; m_arr = '0; m_lea = '0;
        for (int i = 0; i < NS; i++) run_len[i] = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < NS; i++) begin
            m_arr[i] = 1'b0;
            m_lea[i] = 1'b0;
            if (m_d2[i] != m_parked[i]) begin
                run_len[i] = run_len[i] + 1;
                if (run_len[i] == DEB + 1) begin
                    m_parked[i] = ~m_parked[i];
                    if (m_parked[i]) m_arr[i] = 1'b1;
                    else             m_lea[i] = 1'b1;
                    run_len[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = bus.sensor[i];
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_parked", bus.parked, m_parked);
        chk("m_arrive", bus.arrive_pulse, m_arr);
        chk("m_leave", bus.leave_pulse, m_lea);
        chk("m_changed", {2'b00, bus.changed}, {2'b00, |(m_arr | m_lea)});
        chk("m_full", {2'b00, bus.full}, {2'b00, &m_parked});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_model();
    endtask

    task automatic settle();
        repeat (14) tick();
    endtask

    int hold [NS];

    initial begin
        bus.sensor = 3'b111;
        model_reset();

        // Plan 1: sensor held high through reset.
        repeat (3) tick();
        chk("t1_in_reset", bus.parked | bus.arrive_pulse | bus.leave_pulse, 3'b000);
        chk("t1_in_reset_flags", {1'b0, bus.changed, bus.full}, 3'b000);
        reset = 1'b0;
        repeat (6) tick();
        chk("t1_before", bus.parked, 3'b000);
        tick();
        chk("t1_parked", bus.parked, 3'b111);
        chk("t1_arrive", bus.arrive_pulse, 3'b111);
        chk("t1_flags", {1'b0, bus.changed, bus.full}, 3'b011);
        tick();
        chk("t1_after", {bus.arrive_pulse[0], bus.changed, bus.full}, 3'b001);

        // Plan 4: slot 2 leaves a full lot.
        settle();
        bus.sensor = 3'b011;
        repeat (6) tick();
        chk("t4_still_full", {2'b00, bus.full}, 3'b001);
        tick();
        chk("t4_parked", bus.parked, 3'b011);
        chk("t4_leave", bus.leave_pulse, 3'b100);
        chk("t4_full_fell", {1'b0, bus.changed, bus.full}, 3'b010);

        // Plan 2: clean single arrival.
        bus.sensor = 3'b000;
        settle();
        bus.sensor = 3'b001;
        repeat (6) tick();
        chk("t2_before", bus.parked, 3'b000);
        tick();
        chk("t2_parked", bus.parked, 3'b001);
        chk("t2_arrive", bus.arrive_pulse, 3'b001);
        chk("t2_leave", bus.leave_pulse, 3'b000);
        tick();
        chk("t2_one_cycle", bus.arrive_pulse, 3'b000);

        // Plan 3: bouncing sensor on slot 1, then stable.
        bus.sensor = 3'b000;
        settle();
        for (int k = 0; k < 6; k++) begin
            bus.sensor[1] = (k % 2 == 0);
            tick();
            chk("t3_no_pulse", bus.arrive_pulse | bus.leave_pulse, 3'b000);
        end
        bus.sensor[1] = 1'b1;
        repeat (6) begin
            tick();
            chk("t3_pending", bus.parked, 3'b000);
        end
        tick();
        chk("t3_parked", bus.parked, 3'b010);
        chk("t3_arrive", bus.arrive_pulse, 3'b010);

        // Plan 5: two simultaneous arrivals.
        bus.sensor = 3'b000;
        settle();
        bus.sensor = 3'b101;
        repeat (7) tick();
        chk("t5_arrive", bus.arrive_pulse, 3'b101);
        chk("t5_changed", {2'b00, bus.changed}, 3'b001);
        tick();
        chk("t5_changed_once", {2'b00, bus.changed}, 3'b000);

        // Plan 6: reset in the middle of a pending arrival.
        bus.sensor = 3'b000;
        settle();
        bus.sensor = 3'b001;
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_reset_parked", bus.parked, 3'b000);
        repeat (2) tick();
        chk("t6_no_pulse", bus.arrive_pulse, 3'b000);
        reset = 1'b0;
        repeat (6) tick();
        chk("t6_before", bus.parked, 3'b000);
        tick();
        chk("t6_parked", bus.parked, 3'b001);
        chk("t6_arrive", bus.arrive_pulse, 3'b001);

        // Randomized traffic with variable hold times per slot.
        for (int i = 0; i < NS; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (hold[i] == 0) begin
                    bus.sensor[i] = $urandom_range(0, 1) == 1;
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i] = hold[i] - 1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_tracker.md
Name: parking_occupancy_tracker

Overview:
Upstream stage of the empty-spot counter. It takes raw, asynchronous, bouncy per-slot presence sensors and turns them into a clean, registered occupancy vector `parked`. That vector drives the zeros/empty counter and the display path directly. The block also produces one-cycle arrival and departure event pulses, plus a lot-full flag, for the gate and display logic.

Parameters:
NUM_SLOTS, 3, number of parking slots; width of the sensor and parked vectors.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a slot changes state; legal range 1..15.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
sensor  input  NUM_SLOTS  raw slot presence sensors (1 = car detected); asynchronous to clk.
parked  output  NUM_SLOTS  debounced occupancy (1 = slot occupied); registered.
arrive_pulse  output  NUM_SLOTS  one-cycle pulse per slot on a 0->1 transition of parked.
leave_pulse  output  NUM_SLOTS  one-cycle pulse per slot on a 1->0 transition of parked.
changed  output  1  one-cycle pulse; OR of all arrive_pulse and leave_pulse bits.
full  output  1  1 when every parked bit is 1; registered in step with parked.

Behaviour:
- Reset (async assert, release on any edge):
  - parked, arrive_pulse, leave_pulse, changed, full = 0.
  - All synchronizer flops = 0, all debounce counters = 0, all slot FSMs in FREE.
- Per slot: 2-flop synchronizer sensor[i] -> s1 -> s2. Slots are fully independent.
- Per-slot FSM, 4 states; counter cnt has width enough for 0..DEBOUNCE_CYCLES:
  - FREE (parked=0): if s2=1, cnt<=1 and go to ARRIVING; else stay, cnt=0.
  - ARRIVING (parked=0): if s2=0, go to FREE and set cnt<=0.
    - If s2=1 and cnt==DEBOUNCE_CYCLES: go to OCCUPIED, parked[i]<=1, arrive_pulse[i]<=1, cnt<=0.
    - Otherwise cnt<=cnt+1.
  - OCCUPIED (parked=1): if s2=0, cnt<=1 and go to LEAVING; else stay.
  - LEAVING (parked=1): mirror of ARRIVING. s2=1 returns to OCCUPIED. s2=0 with cnt==DEBOUNCE_CYCLES goes to FREE, parked[i]<=0, leave_pulse[i]<=1.
- The counter is compared against DEBOUNCE_CYCLES, not DEBOUNCE_CYCLES-1.
- Latency: sensor[i] rises before edge 1 and stays high. s2=1 after edge 2. parked[i]=1 after edge 3+DEBOUNCE_CYCLES, which is edge 7 at the default.
- Glitch rejection: any opposite s2 sample before the count completes aborts the pending state. The counter restarts from scratch on the next change.
- Pulses:
  - Registered, high for exactly one cycle, coincident with the parked edge.
  - arrive_pulse[i] and leave_pulse[i] are never both high.
  - A slot cannot pulse two cycles in a row (minimum period = DEBOUNCE_CYCLES+1).
- Simultaneous events: several slots may pulse in the same cycle. changed is then a single-cycle 1, not a count.
- full = &parked, registered on the same edge as parked.
- Reset mid-debounce: pending transitions are discarded and all slots are FREE.
  - A sensor held high through reset produces parked=1 at edge 3+DEBOUNCE_CYCLES after release, with an arrive_pulse.
- No X propagation: every flop is reset.

Decomposition:
- Shared package parking_pkg:
  - NUM_SLOTS default.
  - DEBOUNCE_CYCLES default.
  - Slot FSM state encoding: FREE=2'b00, ARRIVING=2'b01, OCCUPIED=2'b11, LEAVING=2'b10. Bit 1 equals parked.
  - Counter width constant.
- Sub-module slot_debouncer:
  - Contains one synchronizer, FSM and counter.
  - Ports: clk, reset, sensor_in, parked_out, arrive_out, leave_out.
  - Instantiated NUM_SLOTS times by generate. The top level ORs the pulses and ANDs parked.

Test Plan:
1. Reset with sensor=3'b111 held -> all outputs 0 during reset. After release, parked=3'b111, arrive_pulse=3'b111, changed=1 and full=1 together at edge 7, for one cycle.
2. sensor[0] 0->1 clean, DEBOUNCE_CYCLES=4 -> parked=3'b001 at edge 7 only, with arrive_pulse=3'b001 for one cycle and leave_pulse=0.
3. sensor[1] bounces 1,0,1,0 per cycle for 6 cycles, then goes stable 1 -> no pulses during the bounce. parked[1] rises exactly 7 edges after the stable 1 begins.
4. From parked=3'b111, sensor[2] drops to 0 -> leave_pulse=3'b100 and parked=3'b011 at edge 7, and full falls on that same edge.
5. sensor[0] and sensor[2] rise on the same edge -> arrive_pulse=3'b101 and a single changed=1 cycle.
6. Reset asserted at edge 4 of a pending arrival -> parked stays 0 with no pulse. After release the arrival completes 7 edges later.
